// File: rtl/guia_ram_pkg.sv
// guia_ram_pkg: shared FSM state type and address range helper for guia_ram
package guia_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/guia_ram_read_port.sv
// guia_ram_read_port: one registered read port with range check and write-first bypass
module guia_ram_read_port
    import guia_ram_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic [WIDTH-1:0]  mem_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // out-of-range reads return zero; a colliding write wins only in write-first mode
    always_comb begin
        valid_d = en_i;
        data_d  = !en_i ? data_q
                : !addr_ok(32'(addr_i), 32'(DEPTH)) ? '0
                : (WRITE_FIRST && we_i && wa_i == addr_i) ? din_i
                : mem_i;
    end

    // output register; data holds whenever no read is issued
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/guia_ram.sv
// guia_ram: register-file RAM with two registered read ports and a self-sequenced clear sweep
module guia_ram
    import guia_ram_pkg::*;
#(
    parameter int   WIDTH       = 4,
    parameter int   DEPTH       = 8,
    parameter bit   WRITE_FIRST = 1'b1,
    localparam int  ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read_enable_a,
    input  logic [ADDR_W-1:0] read_address_a,
    input  logic              read_enable_b,
    input  logic [ADDR_W-1:0] read_address_b,
    output logic [WIDTH-1:0]  data_out_a,
    output logic [WIDTH-1:0]  data_out_b,
    output logic              valid_a,
    output logic              valid_b,
    output logic              busy
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              idle, we_eff;
    logic [WIDTH-1:0]  mem_a, mem_b;

    // state and sweep pointer; reset restarts the sweep from entry 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // sweep advances one entry per cycle; clear is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            state_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? IDLE : CLEAR;
            ptr_d   = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
        end else if (clear) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end
    end

    // decoded controls; a clear request drops a write in the same cycle
    always_comb begin
        busy   = state_q == CLEAR;
        idle   = state_q == IDLE;
        we_eff = idle && write_enable && !clear && addr_ok(32'(write_address), 32'(DEPTH));
        mem_a  = addr_ok(32'(read_address_a), 32'(DEPTH)) ? mem_q[read_address_a] : '0;
        mem_b  = addr_ok(32'(read_address_b), 32'(DEPTH)) ? mem_q[read_address_b] : '0;
    end

    // storage has no reset; the sweep zeroes it instead
    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (we_eff) begin
            mem_q[write_address] <= data_in;
        end
    end

    guia_ram_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WRITE_FIRST(WRITE_FIRST)
    ) u_port_a (
        .clock(clock), .reset(reset), .en_i(read_enable_a && idle), .addr_i(read_address_a),
        .we_i(we_eff), .wa_i(write_address), .din_i(data_in), .mem_i(mem_a),
        .data_o(data_out_a), .valid_o(valid_a)
    );

    guia_ram_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WRITE_FIRST(WRITE_FIRST)
    ) u_port_b (
        .clock(clock), .reset(reset), .en_i(read_enable_b && idle), .addr_i(read_address_b),
        .we_i(we_eff), .wa_i(write_address), .din_i(data_in), .mem_i(mem_b),
        .data_o(data_out_b), .valid_o(valid_b)
    );

endmodule

// File: tb/tb_guia_ram.sv
// tb_guia_ram: directed table-driven bench for an 8-entry write-first and a 6-entry read-first guia_ram
module tb_guia_ram;

    logic       clock = 1'b0;
    logic       reset, clear, write_enable, read_enable_a, read_enable_b;
    logic [2:0] write_address, read_address_a, read_address_b;
    logic [3:0] data_in;
    logic [3:0] da8, db8, da6, db6;
    logic       va8, vb8, va6, vb6, busy8, busy6;
    int         tests = 0;
    int         fails = 0;

    always #5 clock = ~clock;

    guia_ram #(.WIDTH(4), .DEPTH(8), .WRITE_FIRST(1'b1)) u8 (
        .clock(clock), .reset(reset), .clear(clear), .write_enable(write_enable),
        .write_address(write_address), .data_in(data_in),
        .read_enable_a(read_enable_a), .read_address_a(read_address_a),
        .read_enable_b(read_enable_b), .read_address_b(read_address_b),
        .data_out_a(da8), .data_out_b(db8), .valid_a(va8), .valid_b(vb8), .busy(busy8)
    );

    guia_ram #(.WIDTH(4), .DEPTH(6), .WRITE_FIRST(1'b0)) u6 (
        .clock(clock), .reset(reset), .clear(clear), .write_enable(write_enable),
        .write_address(write_address), .data_in(data_in),
        .read_enable_a(read_enable_a), .read_address_a(read_address_a),
        .read_enable_b(read_enable_b), .read_address_b(read_address_b),
        .data_out_a(da6), .data_out_b(db6), .valid_a(va6), .valid_b(vb6), .busy(busy6)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [3:0] din;
        logic       rea;
        logic [2:0] raa;
        logic       reb;
        logic [2:0] rab;
        logic [3:0] ea8, eb8, ea6, eb6;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [3:0] din,
                                input logic rea, input logic [2:0] raa,
                                input logic reb, input logic [2:0] rab,
                                input logic [3:0] ea8, input logic [3:0] eb8,
                                input logic [3:0] ea6, input logic [3:0] eb6);
        vec_t r;
        r.we = we; r.wa = wa; r.din = din; r.rea = rea; r.raa = raa; r.reb = reb; r.rab = rab;
        r.ea8 = ea8; r.eb8 = eb8; r.ea6 = ea6; r.eb6 = eb6;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; write_enable = 0; write_address = 0; data_in = 0;
        read_enable_a = 0; read_address_a = 0; read_enable_b = 0; read_address_b = 0;
    endtask

    // counts busy cycles of both instances, the first observation being already counted in c8/c6
    task automatic count_busy(inout int c8, inout int c6);
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy8) c8++;
            if (busy6) c6++;
            if (!busy8 && !busy6) break;
        end
    endtask

    initial begin
        int c8, c6;
        idle_inputs();
        reset = 1;
        step();
        chk("reset busy8", busy8, 1);
        chk("reset busy6", busy6, 1);
        chk("reset valid_a8", va8, 0);
        chk("reset data_a8", da8, 0);
        chk("reset data_b6", db6, 0);
        reset = 0;
        c8 = 1; c6 = 1;
        count_busy(c8, c6);
        chk("init busy len 8", c8, 8);
        chk("init busy len 6", c6, 6);

        for (int i = 0; i < 8; i++) vt[i] = mk(0, 0, 0, 1, 3'(i), 0, 0, 0, 0, 0, 0);
        vt[8]  = mk(1, 3, 4'hA, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        vt[9]  = mk(0, 0, 4'h0, 1, 3, 1, 2, 4'hA, 4'h0, 4'hA, 4'h0);
        vt[10] = mk(1, 5, 4'hA, 0, 0, 0, 0, 4'hA, 4'h0, 4'hA, 4'h0);
        vt[11] = mk(1, 5, 4'h5, 1, 5, 1, 5, 4'h5, 4'h5, 4'hA, 4'hA);
        vt[12] = mk(0, 0, 4'h0, 1, 5, 0, 0, 4'h5, 4'h5, 4'h5, 4'hA);
        vt[13] = mk(1, 7, 4'hF, 0, 0, 0, 0, 4'h5, 4'h5, 4'h5, 4'hA);
        vt[14] = mk(0, 0, 4'h0, 1, 7, 1, 6, 4'hF, 4'h0, 4'h0, 4'h0);
        vt[15] = mk(0, 0, 4'h0, 1, 1, 1, 3, 4'h0, 4'hA, 4'h0, 4'hA);
        vt[16] = mk(0, 0, 4'h0, 1, 3, 1, 7, 4'hA, 4'hF, 4'hA, 4'h0);

        for (int i = 0; i < 17; i++) begin
            write_enable = vt[i].we; write_address = vt[i].wa; data_in = vt[i].din;
            read_enable_a = vt[i].rea; read_address_a = vt[i].raa;
            read_enable_b = vt[i].reb; read_address_b = vt[i].rab;
            step();
            chk($sformatf("vec%0d data_a8", i), da8, vt[i].ea8);
            chk($sformatf("vec%0d data_b8", i), db8, vt[i].eb8);
            chk($sformatf("vec%0d data_a6", i), da6, vt[i].ea6);
            chk($sformatf("vec%0d data_b6", i), db6, vt[i].eb6);
            chk($sformatf("vec%0d valid_a8", i), va8, vt[i].rea);
            chk($sformatf("vec%0d valid_b6", i), vb6, vt[i].reb);
            chk($sformatf("vec%0d busy8", i), busy8, 0);
        end

        // clear together with a write: write dropped, reads ignored while busy, second clear ignored
        idle_inputs();
        clear = 1; write_enable = 1; write_address = 0; data_in = 4'hC;
        step();
        idle_inputs();
        c8 = busy8 ? 1 : 0;
        c6 = busy6 ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            read_enable_a = 1; read_address_a = 3;
            clear = (i == 2);
            step();
            if (busy8) begin
                c8++;
                chk("busy valid_a8", va8, 0);
                chk("busy hold data_a8", da8, 4'hA);
            end
            if (busy6) begin
                c6++;
                chk("busy valid_a6", va6, 0);
            end
            if (!busy8) break;
        end
        idle_inputs();
        chk("clear busy len 8", c8, 8);
        chk("clear busy len 6", c6, 6);
        for (int i = 0; i < 8; i++) begin
            read_enable_a = 1; read_address_a = 3'(i);
            read_enable_b = 1; read_address_b = 3'(i);
            step();
            chk($sformatf("cleared a8[%0d]", i), da8, 0);
            chk($sformatf("cleared b6[%0d]", i), db6, 0);
            chk($sformatf("cleared valid_b8[%0d]", i), vb8, 1);
        end

        // reset in the middle of a sweep restarts it with the full length
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
        step();
        step();
        reset = 1;
        step();
        chk("mid reset data_a8", da8, 0);
        chk("mid reset busy8", busy8, 1);
        reset = 0;
        c8 = 1; c6 = 1;
        count_busy(c8, c6);
        chk("restart busy len 8", c8, 8);
        chk("restart busy len 6", c6, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
